// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Definitions shared by the UART transmit and receive paths.
//   uart_state_e        : frame sequencer states (IDLE, START, DATA, PARITY, STOP)
//   UART_IDLE           : line level while no frame is in flight (mark)
//   UART_START          : line level of the start bit (space)
//   UART_FRAME_OVERHEAD : non-data bits per frame (start + parity + stop)
//   uart_frame_cycles() : clock cycles occupied by one complete frame
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

    localparam int UART_FRAME_OVERHEAD = 3;

    // Total frame duration in clock cycles for a given word length and
    // bit period.
    function automatic int uart_frame_cycles(input int word_length,
                                             input int clks_per_bit);
        return (word_length + UART_FRAME_OVERHEAD) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps, flagging the final
// cycle of every bit period with a one-cycle bit_end tick.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//
// Ports
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clear   : synchronous clear; holds the count at 0 while asserted
//   count   : current position inside the bit period
//   bit_end : high during the last cycle of a bit period (never while clear)
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16,
    localparam int CNT_W       = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             bit_end
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic at_last;

    assign at_last = (count == LAST_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || at_last) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // The count sits at 0 while cleared, so gating with clear only matters
    // for the degenerate case where LAST_COUNT would otherwise match.
    assign bit_end = !clear && at_last;

endmodule

// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
//
// Parity-generating UART transmitter. On an accepted request it latches one
// word and sends: start bit, WORD_LENGTH data bits LSB-first, parity bit,
// stop bit. Each bit lasts CLKS_PER_BIT clock cycles, timed internally.
//
// Parameters
//   WORD_LENGTH  : data bits per frame (>= 2)
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   PARITY_ODD   : 0 = even parity, 1 = odd parity
//
// Ports
//   Clk         : system clock, rising edge
//   Reset       : asynchronous active-low reset
//   Parallel_In : word to send, sampled only when a request is accepted
//   Transmit    : level request
//   Serial_Out  : serial line, idle high, registered
//   Busy        : frame in progress, registered
//   Tx_Done     : one-cycle pulse in the last cycle of the stop bit, registered
//   dbg_state   : current sequencer state (uart_state_e encoding)
//
// Request handshake: Transmit acts as a valid and !Busy as the ready. A
// request is taken on a rising edge where Transmit = 1 and Busy = 0; at any
// other time Transmit is ignored, nothing is queued and the latched word is
// untouched. Busy stays high through the Tx_Done cycle and drops on the next
// edge, so holding Transmit high yields frames separated by one idle cycle.
// -----------------------------------------------------------------------------
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int WORD_LENGTH  = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [WORD_LENGTH-1:0] Parallel_In,
    input  logic                   Transmit,
    output logic                   Serial_Out,
    output logic                   Busy,
    output logic                   Tx_Done,
    output logic [2:0]             dbg_state
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(WORD_LENGTH);

    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_LENGTH - 1);
    // Count value one cycle before the end of a bit period; used to register
    // Tx_Done so it lands exactly on the final stop-bit cycle.
    localparam logic [BAUD_W-1:0] DONE_AT  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic              ODD_BIT  = (PARITY_ODD != 0);

    uart_state_e            state_q,   state_n;
    logic [WORD_LENGTH-1:0] shift_q,   shift_n;
    logic                   parity_q,  parity_n;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_n;
    logic                   serial_q,  serial_n;
    logic                   busy_q,    busy_n;
    logic                   done_q,    done_n;

    logic [BAUD_W-1:0]      baud_cnt;
    logic                   bit_end;
    logic                   baud_clear;

    // Holding the timer cleared for the whole idle period means it starts
    // from 0 on the first cycle of the start bit, whenever a request lands.
    assign baud_clear = (state_q == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (Clk),
        .rst_n   (Reset),
        .clear   (baud_clear),
        .count   (baud_cnt),
        .bit_end (bit_end)
    );

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            serial_q  <= UART_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            shift_q   <= shift_n;
            parity_q  <= parity_n;
            bit_cnt_q <= bit_cnt_n;
            serial_q  <= serial_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so the registered line changes on the same edge as the
    // state does.
    // -------------------------------------------------------------------------
    always_comb begin
        state_n   = state_q;
        shift_n   = shift_q;
        parity_n  = parity_q;
        bit_cnt_n = bit_cnt_q;
        serial_n  = serial_q;
        busy_n    = busy_q;
        done_n    = 1'b0;

        unique case (state_q)
            IDLE: begin
                serial_n = UART_IDLE;
                busy_n   = 1'b0;
                if (Transmit) begin
                    state_n  = START;
                    shift_n  = Parallel_In;
                    parity_n = (^Parallel_In) ^ ODD_BIT;
                    serial_n = UART_START;
                    busy_n   = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    serial_n  = shift_q[0];
                end
            end

            DATA: begin
                if (bit_end) begin
                    shift_n = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_n   = PARITY;
                        bit_cnt_n = '0;
                        serial_n  = parity_q;
                    end else begin
                        bit_cnt_n = bit_cnt_q + BIT_W'(1);
                        // shift_q[1] is the bit that shift_n[0] will hold.
                        serial_n  = shift_q[1];
                    end
                end
            end

            PARITY: begin
                if (bit_end) begin
                    state_n  = STOP;
                    serial_n = UART_IDLE;
                end
            end

            STOP: begin
                if (baud_cnt == DONE_AT) begin
                    done_n = 1'b1;
                end
                if (bit_end) begin
                    state_n  = IDLE;
                    serial_n = UART_IDLE;
                    busy_n   = 1'b0;
                end
            end

            default: begin
                state_n  = IDLE;
                serial_n = UART_IDLE;
                busy_n   = 1'b0;
            end
        endcase
    end

    assign Serial_Out = serial_q;
    assign Busy       = busy_q;
    assign Tx_Done    = done_q;
    assign dbg_state  = state_q;

endmodule
